ps2_key_ctrl: RTL and testbench



---
 rtl/ps2_key_ctrl.sv | 151 +++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_ctrl
// Description : PS/2 scan-code sequencer for PONG. Parses make, break (F0)
//               and extended (E0) prefixes, keeps held flags for the five
//               game keys, decodes paddle directions, pulses start on a
//               fresh Space press, and aborts stalled prefix sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_code,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_pulse,
    output logic       seq_err
);

    localparam logic [7:0] c_CODE_BRK = 8'hF0;
    localparam logic [7:0] c_CODE_EXT = 8'hE0;
    localparam logic [7:0] c_CODE_W   = 8'h1D;
    localparam logic [7:0] c_CODE_S   = 8'h1B;
    localparam logic [7:0] c_CODE_SP  = 8'h29;
    localparam logic [7:0] c_CODE_UP  = 8'h75;
    localparam logic [7:0] c_CODE_DN  = 8'h72;

    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_start;
    logic             r_w_h;
    logic             r_s_h;
    logic             r_up_h;
    logic             r_dn_h;
    logic             r_sp_h;

    logic w_is_prefix;
    logic w_key_evt;
    logic w_key_make;
    logic w_key_ext;

    // A non-prefix byte always terminates the sequence as a key event; the
    // current state tells whether it is a make/break and extended or not.
    assign w_is_prefix = (rx_code == c_CODE_BRK) || (rx_code == c_CODE_EXT);
    assign w_key_evt   = rx_done && !w_is_prefix;
    assign w_key_make  = (r_state == S_IDLE) || (r_state == S_EXT);
    assign w_key_ext   = (r_state == S_EXT)  || (r_state == S_EXT_BRK);

    // Prefix sequencer with stall watchdog; an incoming byte beats the timeout.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (rx_done) begin
                r_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (rx_code == c_CODE_BRK)      r_state <= S_BRK;
                        else if (rx_code == c_CODE_EXT) r_state <= S_EXT;
                        else                            r_state <= S_IDLE;
                    end
                    S_BRK: begin
                        r_err   <= w_is_prefix;
                        r_state <= S_IDLE;
                    end
                    S_EXT: begin
                        if (rx_code == c_CODE_BRK)      r_state <= S_EXT_BRK;
                        else if (rx_code == c_CODE_EXT) r_state <= S_EXT;
                        else                            r_state <= S_IDLE;
                    end
                    S_EXT_BRK: begin
                        r_err   <= w_is_prefix;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt == c_TERM) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_err   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    // Held-key flags and the fresh-Space start pulse, updated on key events.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_w_h   <= 1'b0;
            r_s_h   <= 1'b0;
            r_up_h  <= 1'b0;
            r_dn_h  <= 1'b0;
            r_sp_h  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_key_evt) begin
                if (w_key_ext) begin
                    case (rx_code)
                        c_CODE_UP: r_up_h <= w_key_make;
                        c_CODE_DN: r_dn_h <= w_key_make;
                        default:   ;
                    endcase
                end else begin
                    case (rx_code)
                        c_CODE_W: r_w_h <= w_key_make;
                        c_CODE_S: r_s_h <= w_key_make;
                        c_CODE_SP: begin
                            r_start <= w_key_make && !r_sp_h;
                            r_sp_h  <= w_key_make;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Opposing keys held together cancel to no movement.
    assign p1_up       = r_w_h  & ~r_s_h;
    assign p1_down     = r_s_h  & ~r_w_h;
    assign p2_up       = r_up_h & ~r_dn_h;
    assign p2_down     = r_dn_h & ~r_up_h;
    assign start_pulse = r_start;
    assign seq_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_ctrl
// Description : Self-checking bench for ps2_key_ctrl with a behavioural
//               key/prefix reference model and randomized byte streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_code = 8'h00;
    logic       p1_up, p1_down, p2_up, p2_down, start_pulse, seq_err;
    logic [5:0] obs;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: held keys, pending prefixes, age of pending prefix.
    bit m_w, m_s, m_up, m_dn, m_sp;
    bit m_pbrk, m_pext;
    int m_age;
    bit m_start, m_err;

    ps2_key_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_code    (rx_code),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .start_pulse(start_pulse),
        .seq_err    (seq_err)
    );

    always #5 clock = ~clock;

    assign obs = {p1_up, p1_down, p2_up, p2_down, start_pulse, seq_err};

    function automatic logic [5:0] exp_vec();
        return {m_w & ~m_s, m_s & ~m_w, m_up & ~m_dn, m_dn & ~m_up, m_start, m_err};
    endfunction

    task automatic m_reset();
        {m_w, m_s, m_up, m_dn, m_sp, m_pbrk, m_pext, m_start, m_err} = '0;
        m_age = 0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        bit make;
        m_start = 0;
        m_err   = 0;
        m_age   = 0;
        if (b == 8'hF0 || b == 8'hE0) begin
            if (m_pbrk) begin
                m_err  = 1;
                m_pbrk = 0;
                m_pext = 0;
            end else if (b == 8'hF0) begin
                m_pbrk = 1;
            end else begin
                m_pext = 1;
            end
        end else begin
            make = !m_pbrk;
            if (m_pext) begin
                if (b == 8'h75) m_up = make;
                if (b == 8'h72) m_dn = make;
            end else begin
                if (b == 8'h1D) m_w = make;
                if (b == 8'h1B) m_s = make;
                if (b == 8'h29) begin
                    m_start = make && !m_sp;
                    m_sp    = make;
                end
            end
            m_pbrk = 0;
            m_pext = 0;
        end
    endtask

    task automatic m_tick();
        m_start = 0;
        m_err   = 0;
        if (m_pbrk || m_pext) begin
            m_age++;
            if (m_age == TIMEOUT) begin
                m_err  = 1;
                m_pbrk = 0;
                m_pext = 0;
                m_age  = 0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_done = 1'b1;
        rx_code = b;
        @(posedge clock);
        m_byte(b);
        @(negedge clock);
        rx_done = 1'b0;
        rx_code = 8'($urandom);
    endtask

    task automatic idle();
        rx_done = 1'b0;
        @(posedge clock);
        m_tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rx_done = 1'b1;
            rx_code = 8'h1D;
            @(posedge clock);
            m_reset();
            @(negedge clock);
            n_checks++;
            if (obs !== 6'b0) begin
                n_fails++;
                $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0);
            end
        end
        rst = 1'b0;
        rx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++;
            if (p1_up !== 1'b0 || obs !== exp_vec()) begin
                n_fails++;
                $display("FAIL reset_release: got %b expected %b", obs, exp_vec());
            end
        end
        // Reset mid-sequence: following 75 must be parsed from idle (keypad).
        send(8'hE0);
        rst = 1'b1;
        @(posedge clock);
        m_reset();
        @(negedge clock);
        rst = 1'b0;
        send(8'h75);
        n_checks++;
        if (p2_up !== 1'b0 || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL reset_midseq: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_make_break();
        logic [7:0] seq [4] = '{8'h1D, 8'hF0, 8'h1D, 8'h75};
        logic       want [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(seq[i]);
            n_checks++;
            if (obs !== exp_vec() || p1_up !== want[i] || p2_up !== 1'b0) begin
                n_fails++;
                $display("FAIL make_break[%0d]: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq  [13] = '{8'hE0, 8'h75, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h75,
                                  8'hE0, 8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h72};
        logic [1:0] want [13] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01,
                                  2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 13; i++) begin
            send(seq[i]);
            n_checks++;
            if (obs !== exp_vec() || {p2_up, p2_down} !== want[i] || seq_err !== 1'b0) begin
                n_fails++;
                $display("FAIL extended[%0d]: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        logic [7:0] seq  [6] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29};
        logic       want [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            send(seq[i]);
            n_checks++;
            if (obs !== exp_vec() || start_pulse !== want[i]) begin
                n_fails++;
                $display("FAIL start[%0d]: got %b expected %b", i, obs, exp_vec());
            end
        end
        idle();
        n_checks++;
        if (start_pulse !== 1'b0 || obs !== exp_vec()) begin
            n_fails++;
            $display("FAIL start_single: got %b expected %b", obs, exp_vec());
        end
        send(8'hF0);
        send(8'h29);
    endtask

    task automatic test_timeout();
        send(8'hE0);
        for (int k = 0; k < 18; k++) begin
            idle();
            n_checks++;
            if (obs !== exp_vec() || seq_err !== (k == 15)) begin
                n_fails++;
                $display("FAIL timeout_idle[%0d]: got %b expected %b", k, obs, exp_vec());
            end
        end
        send(8'h1D);
        n_checks++;
        if (obs !== exp_vec() || p1_up !== 1'b1 || p2_up !== 1'b0 || p2_down !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_recover: got %b expected %b", obs, exp_vec());
        end
        send(8'hE0);
        for (int k = 0; k < 15; k++) begin
            idle();
            n_checks++;
            if (obs !== exp_vec() || seq_err !== 1'b0) begin
                n_fails++;
                $display("FAIL terminal_wait[%0d]: got %b expected %b", k, obs, exp_vec());
            end
        end
        send(8'h75);
        n_checks++;
        if (obs !== exp_vec() || p2_up !== 1'b1 || seq_err !== 1'b0) begin
            n_fails++;
            $display("FAIL terminal_byte_wins: got %b expected %b", obs, exp_vec());
        end
        for (int k = 0; k < 20; k++) begin
            idle();
            n_checks++;
            if (obs !== exp_vec() || seq_err !== 1'b0) begin
                n_fails++;
                $display("FAIL terminal_after[%0d]: got %b expected %b", k, obs, exp_vec());
            end
        end
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h1D);
    endtask

    task automatic test_illegal();
        send(8'hF0);
        send(8'hF0);
        n_checks++;
        if (obs !== exp_vec() || seq_err !== 1'b1 || p1_up !== 1'b0 || p1_down !== 1'b0) begin
            n_fails++;
            $display("FAIL illegal_prefix: got %b expected %b", obs, exp_vec());
        end
        send(8'h1B);
        n_checks++;
        if (obs !== exp_vec() || p1_down !== 1'b1 || seq_err !== 1'b0) begin
            n_fails++;
            $display("FAIL illegal_recover: got %b expected %b", obs, exp_vec());
        end
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        n_checks++;
        if (obs !== exp_vec() || seq_err !== 1'b1) begin
            n_fails++;
            $display("FAIL illegal_ext_brk: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int         r;
        int         n;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 10));
            if (r >= 8) begin
                n = ($urandom_range(0, 7) == 0) ? 18 : int'($urandom_range(1, 3));
                for (int j = 0; j < n; j++) begin
                    idle();
                    n_checks++;
                    if (obs !== exp_vec()) begin
                        n_fails++;
                        $display("FAIL random_idle[%0d]: got %b expected %b", i, obs, exp_vec());
                    end
                end
            end else begin
                case (r)
                    0:       b = 8'hF0;
                    1:       b = 8'hE0;
                    2:       b = 8'h1D;
                    3:       b = 8'h1B;
                    4:       b = 8'h29;
                    5:       b = 8'h75;
                    6:       b = 8'h72;
                    default: b = 8'($urandom);
                endcase
                send(b);
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fails++;
                    $display("FAIL random_byte[%0d] code %h: got %b expected %b", i, b, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        m_reset();
        @(negedge clock);
        test_reset();
        test_make_break();
        test_extended();
        test_start();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
